ball_motion: RTL

// - 2-D ball position engine for pong. Each axis has its own speed threshold and direction.
// - Top/bottom walls reflect the ball. Left/right edges score a point and return the ball to centre.
// - Sits between the game controller (serve, speed, paddle-hit reflect) and the video renderer (x, y).
// - Next generation of the single-axis coordinate mover.

---
 rtl/pong_pkg.sv | 20 ++
 rtl/axis_stepper.sv | 93 +++++++++
 rtl/ball_motion.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// ============================================================================
// pong_pkg : shared types and encodings for the pong ball motion engine
// Revision : 1.0
// ============================================================================
`default_nettype none

package pong_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SCORED = 2'd2
    } motion_state_t;

    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

endpackage

`default_nettype wire

// File: rtl/axis_stepper.sv
// ============================================================================
// axis_stepper : one coordinate axis with step timer, position and direction
// Revision     : 1.0
// ============================================================================
`default_nettype none

module axis_stepper
    import pong_pkg::*;
#(
    parameter int W       = 10,
    parameter int TW      = 32,
    parameter int MAX     = 639,
    parameter int CENTER  = 320,
    parameter int REFLECT = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic          dir_load_i,
    input  logic          run_i,
    input  logic          invert_i,
    input  logic [TW-1:0] threshold_i,
    output logic [W-1:0]  pos_o,
    output logic          dir_o,
    output logic          edge_hit_o
);

    localparam logic [W-1:0] C_MAX    = W'(MAX);
    localparam logic [W-1:0] C_CENTER = W'(CENTER);
    localparam logic [W-1:0] C_ONE    = W'(1);

    logic [W-1:0]  pos_q, pos_d;
    logic          dir_q, dir_d;
    logic [TW-1:0] timer_q, timer_d;

    logic w_dir_eff;
    logic w_step;
    logic w_at_edge;

    // A same-cycle invert steers the step that fires in this cycle.
    assign w_dir_eff  = dir_q ^ invert_i;
    assign w_step     = run_i && (timer_q >= threshold_i);
    assign w_at_edge  = (w_dir_eff == DIR_POS) ? (pos_q == C_MAX) : (pos_q == '0);
    assign edge_hit_o = w_step && w_at_edge;

    always_comb begin
        pos_d   = pos_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        if (clear_i) begin
            pos_d   = C_CENTER;
            timer_d = '0;
        end else if (load_i) begin
            dir_d   = dir_load_i;
            timer_d = '0;
        end else if (run_i) begin
            dir_d = w_dir_eff;
            if (w_step) begin
                timer_d = '0;
                if (w_at_edge) begin
                    // Exit axes hold position; the owner recentres it.
                    if (REFLECT != 0) begin
                        dir_d = (w_dir_eff == DIR_POS) ? DIR_NEG : DIR_POS;
                        pos_d = (w_dir_eff == DIR_POS) ? (C_MAX - C_ONE) : C_ONE;
                    end
                end else begin
                    pos_d = (w_dir_eff == DIR_POS) ? (pos_q + C_ONE) : (pos_q - C_ONE);
                end
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos_q   <= C_CENTER;
            dir_q   <= DIR_POS;
            timer_q <= '0;
        end else begin
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
        end
    end

    assign pos_o = pos_q;
    assign dir_o = dir_q;

endmodule

`default_nettype wire

// File: rtl/ball_motion.sv
// ============================================================================
// ball_motion : 2-D pong ball engine with wall reflection and edge scoring
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ball_motion
    import pong_pkg::*;
#(
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int TW       = 32,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int X_CENTER = 320,
    parameter int Y_CENTER = 240
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          active,
    input  logic          serve,
    input  logic          serve_dir_x,
    input  logic          serve_dir_y,
    input  logic [TW-1:0] x_threshold,
    input  logic [TW-1:0] y_threshold,
    input  logic          reflect_x,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          dir_x,
    output logic          dir_y,
    output logic          moving,
    output logic          wall_bounce,
    output logic          score_left,
    output logic          score_right
);

    motion_state_t state_q, state_d;
    logic moving_q, moving_d;
    logic wall_q, wall_d;
    logic sl_q, sl_d;
    logic sr_q, sr_d;

    logic w_clear;
    logic w_load;
    logic w_run;
    logic w_x_edge;
    logic w_y_edge;

    axis_stepper #(
        .W       (XW),
        .TW      (TW),
        .MAX     (X_MAX),
        .CENTER  (X_CENTER),
        .REFLECT (0)
    ) u_x_axis (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (w_clear),
        .load_i      (w_load),
        .dir_load_i  (serve_dir_x),
        .run_i       (w_run),
        .invert_i    (w_run && reflect_x),
        .threshold_i (x_threshold),
        .pos_o       (x),
        .dir_o       (dir_x),
        .edge_hit_o  (w_x_edge)
    );

    axis_stepper #(
        .W       (YW),
        .TW      (TW),
        .MAX     (Y_MAX),
        .CENTER  (Y_CENTER),
        .REFLECT (1)
    ) u_y_axis (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (w_clear),
        .load_i      (w_load),
        .dir_load_i  (serve_dir_y),
        .run_i       (w_run),
        .invert_i    (1'b0),
        .threshold_i (y_threshold),
        .pos_o       (y),
        .dir_o       (dir_y),
        .edge_hit_o  (w_y_edge)
    );

    always_comb begin
        state_d = state_q;
        wall_d  = 1'b0;
        sl_d    = 1'b0;
        sr_d    = 1'b0;
        w_clear = 1'b0;
        w_load  = 1'b0;
        w_run   = 1'b0;
        if (!active) begin
            state_d = IDLE;
            w_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (serve) begin
                        state_d = RUN;
                        w_load  = 1'b1;
                    end
                end
                RUN: begin
                    w_run = 1'b1;
                    // A score swallows a coincident wall bounce.
                    if (w_x_edge) begin
                        state_d = SCORED;
                        if (x == XW'(X_MAX)) sr_d = 1'b1;
                        else                 sl_d = 1'b1;
                    end else begin
                        wall_d = w_y_edge;
                    end
                end
                SCORED: begin
                    w_clear = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    w_clear = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
        moving_d = (state_d == RUN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            moving_q <= 1'b0;
            wall_q   <= 1'b0;
            sl_q     <= 1'b0;
            sr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            moving_q <= moving_d;
            wall_q   <= wall_d;
            sl_q     <= sl_d;
            sr_q     <= sr_d;
        end
    end

    assign moving      = moving_q;
    assign wall_bounce = wall_q;
    assign score_left  = sl_q;
    assign score_right = sr_q;

endmodule

`default_nettype wire
